// File: rtl/sync_fifo_pkg.sv
// Shared defaults and read-mode encoding for the sync_fifo_ext block family.
package sync_fifo_pkg;

    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_AE_LEVEL   = 2;
    localparam int DEF_FWFT       = 1;

    typedef enum logic {
        MODE_REGISTERED = 1'b0,
        MODE_FWFT       = 1'b1
    } rd_mode_e;

    function automatic rd_mode_e rd_mode_from_param(input int fwft);
        return (fwft != 0) ? MODE_FWFT : MODE_REGISTERED;
    endfunction

endpackage

// File: rtl/reg_file.sv
// Simple dual-port register array: one synchronous write port, one combinational read port.
// No reset on the storage; contents are don't-care until written.
module reg_file #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// FIFO bookkeeping: pointers, occupancy, status flags and sticky error flags.
// Flags decode only from the registered count; accept strobes are combinational from wr/rd.
module sync_fifo_ctrl #(
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic                  wr_i,
    input  logic                  rd_i,
    output logic                  wr_accept_o,
    output logic                  rd_accept_o,
    output logic [ADDR_WIDTH-1:0] w_addr_o,
    output logic [ADDR_WIDTH-1:0] r_addr_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AF_CNT    = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_CNT    = AE_LEVEL[ADDR_WIDTH:0];

    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  full, empty, wr_acc, rd_acc, quiet;

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);
    // Accepts are suppressed while reset/flush own the cycle so memory is left untouched.
    assign quiet  = reset_i || flush_i;
    assign rd_acc = !quiet && rd_i && !empty;
    assign wr_acc = !quiet && wr_i && (!full || rd_acc);

    always_comb begin
        w_addr_d    = w_addr_q;
        r_addr_d    = r_addr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_acc) begin
            w_addr_d = w_addr_q + ADDR_WIDTH'(1);
        end
        if (rd_acc) begin
            r_addr_d = r_addr_q + ADDR_WIDTH'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
            default: count_d = count_q;
        endcase
        if (wr_i && full && !rd_acc) begin
            overflow_d = 1'b1;
        end
        if (rd_i && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i || flush_i) begin
            w_addr_q    <= '0;
            r_addr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_addr_q    <= w_addr_d;
            r_addr_q    <= r_addr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign wr_accept_o    = wr_acc;
    assign rd_accept_o    = rd_acc;
    assign w_addr_o       = w_addr_q;
    assign r_addr_o       = r_addr_q;
    assign count_o        = count_q;
    assign full_o         = full;
    assign empty_o        = empty;
    assign almost_full_o  = (count_q >= AF_CNT);
    assign almost_empty_o = (count_q <= AE_CNT);
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule

// File: rtl/sync_fifo_ext.sv
// Synchronous FIFO with status/error flags; FWFT shows the head combinationally, registered mode
// returns read data one cycle after the accepted rd. Full rejects writes unless a read frees a slot.
module sync_fifo_ext
    import sync_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int AF_LEVEL   = (2**ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = DEF_AE_LEVEL,
    parameter int FWFT       = DEF_FWFT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int       DEPTH   = 2**ADDR_WIDTH;
    localparam rd_mode_e RD_MODE = rd_mode_from_param(FWFT);

    if (!(AE_LEVEL >= 0 && AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_param_check
        $error("sync_fifo_ext: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic                  wr_accept, rd_accept;
    logic [ADDR_WIDTH-1:0] w_addr, r_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    sync_fifo_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .AF_LEVEL   (AF_LEVEL),
        .AE_LEVEL   (AE_LEVEL)
    ) u_ctrl (
        .clk            (clk),
        .reset_i        (reset),
        .flush_i        (flush),
        .wr_i           (wr),
        .rd_i           (rd),
        .wr_accept_o    (wr_accept),
        .rd_accept_o    (rd_accept),
        .w_addr_o       (w_addr),
        .r_addr_o       (r_addr),
        .count_o        (count),
        .full_o         (full),
        .empty_o        (empty),
        .almost_full_o  (almost_full),
        .almost_empty_o (almost_empty),
        .overflow_o     (overflow),
        .underflow_o    (underflow)
    );

    reg_file #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en_i (wr_accept),
        .waddr_i (w_addr),
        .wdata_i (w_data),
        .raddr_i (r_addr),
        .rdata_o (mem_rdata)
    );

    if (RD_MODE == MODE_FWFT) begin : g_fwft
        // Unwritten storage is never exposed: an empty FIFO presents zero.
        assign r_valid = !empty;
        assign r_data  = empty ? '0 : mem_rdata;
    end else begin : g_registered
        logic [DATA_WIDTH-1:0] r_data_q;
        logic                  r_valid_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_data_q  <= '0;
                r_valid_q <= 1'b0;
            end else if (flush) begin
                r_valid_q <= 1'b0;
            end else begin
                r_valid_q <= rd_accept;
                if (rd_accept) begin
                    r_data_q <= mem_rdata;
                end
            end
        end

        assign r_valid = r_valid_q;
        assign r_data  = r_data_q;
    end

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Directed bench for sync_fifo_ext: table-driven FWFT vectors plus wrap, flush, reset and registered-read sequences.
module tb_sync_fifo_ext;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // FWFT instance
    logic       reset, flush, wr, rd;
    logic [7:0] w_data, r_data;
    logic       r_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;

    // registered-read instance
    logic       g_reset, g_flush, g_wr, g_rd;
    logic [7:0] g_w_data, g_r_data;
    logic       g_r_valid, g_full, g_empty, g_af, g_ae, g_ov, g_un;
    logic [3:0] g_count;

    sync_fifo_ext #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .FWFT(1)) u_dut (
        .clk(clk), .reset(reset), .flush(flush), .wr(wr), .w_data(w_data), .rd(rd),
        .r_data(r_data), .r_valid(r_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_ext #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .FWFT(0)) u_dut_reg (
        .clk(clk), .reset(g_reset), .flush(g_flush), .wr(g_wr), .w_data(g_w_data), .rd(g_rd),
        .r_data(g_r_data), .r_valid(g_r_valid), .full(g_full), .empty(g_empty),
        .almost_full(g_af), .almost_empty(g_ae), .count(g_count),
        .overflow(g_ov), .underflow(g_un)
    );

    typedef struct {
        logic       rs, fl, w, r;
        logic [7:0] wd;
        int         cnt;
        logic       ov, un;
        logic [7:0] head;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rs, input logic fl, input logic w, input logic r,
                       input logic [7:0] wd, input int cnt, input logic ov, input logic un,
                       input logic [7:0] head);
        vec_t v;
        v.rs = rs; v.fl = fl; v.w = w; v.r = r; v.wd = wd;
        v.cnt = cnt; v.ov = ov; v.un = un; v.head = head;
        vecs.push_back(v);
    endtask

    // Flags follow directly from occupancy: AF_LEVEL=6, AE_LEVEL=2, DEPTH=8.
    task automatic check_main(input string tag, input int cnt, input logic ov, input logic un,
                              input logic [7:0] head);
        check({tag, " count"},        32'(count),        cnt);
        check({tag, " full"},         32'(full),         32'(cnt == DEPTH));
        check({tag, " empty"},        32'(empty),        32'(cnt == 0));
        check({tag, " almost_full"},  32'(almost_full),  32'(cnt >= 6));
        check({tag, " almost_empty"}, 32'(almost_empty), 32'(cnt <= 2));
        check({tag, " r_valid"},      32'(r_valid),      32'(cnt != 0));
        check({tag, " r_data"},       32'(r_data),       (cnt == 0) ? 32'h0 : 32'(head));
        check({tag, " overflow"},     32'(overflow),     32'(ov));
        check({tag, " underflow"},    32'(underflow),    32'(un));
    endtask

    task automatic step_main(input logic rs, input logic fl, input logic w, input logic r,
                             input logic [7:0] wd);
        reset = rs; flush = fl; wr = w; rd = r; w_data = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic step_reg(input logic rs, input logic fl, input logic w, input logic r,
                            input logic [7:0] wd);
        g_reset = rs; g_flush = fl; g_wr = w; g_rd = r; g_w_data = wd;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] mq[$];
    logic       m_ov, m_un;

    initial begin
        reset = 1'b1; flush = 1'b0; wr = 1'b0; rd = 1'b0; w_data = '0;
        g_reset = 1'b1; g_flush = 1'b0; g_wr = 1'b0; g_rd = 1'b0; g_w_data = '0;

        // ---- vector table ----
        add(1, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        for (int k = 1; k <= 8; k++) add(0, 0, 1, 0, 8'(k), k, 0, 0, 8'h01);
        add(0, 0, 1, 0, 8'h99, 8, 1, 0, 8'h01);
        for (int j = 1; j <= 8; j++) add(0, 0, 0, 1, 8'h00, 8 - j, 1, 0, 8'(j + 1));
        add(0, 0, 0, 1, 8'h00, 0, 1, 1, 8'h00);
        add(0, 1, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        for (int k = 0; k < 8; k++) add(0, 0, 1, 0, 8'(8'h11 + k), k + 1, 0, 0, 8'h11);
        add(0, 0, 1, 1, 8'hAA, 8, 0, 0, 8'h12);
        for (int j = 1; j <= 8; j++)
            add(0, 0, 0, 1, 8'h00, 8 - j, 0, 0, (j == 7) ? 8'hAA : 8'(8'h12 + j));
        add(0, 0, 1, 1, 8'h55, 1, 0, 1, 8'h55);
        add(0, 0, 0, 1, 8'h00, 0, 0, 1, 8'h00);
        add(1, 0, 1, 1, 8'h77, 0, 0, 0, 8'h00);

        foreach (vecs[i]) begin
            step_main(vecs[i].rs, vecs[i].fl, vecs[i].w, vecs[i].r, vecs[i].wd);
            check_main($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ov, vecs[i].un, vecs[i].head);
        end

        // ---- pointer wrap: 20 writes with interleaved reads against a queue model ----
        mq.delete(); m_ov = 1'b0; m_un = 1'b0;
        for (int i = 0; i < 20; i++) begin
            logic r_req, r_acc, w_acc;
            r_req = (i % 3) != 0;
            r_acc = r_req && (mq.size() != 0);
            w_acc = (mq.size() < DEPTH) || r_acc;
            if (r_req && mq.size() == 0) m_un = 1'b1;
            step_main(0, 0, 1, r_req, 8'(8'h40 + i));
            if (r_acc) void'(mq.pop_front());
            if (w_acc) mq.push_back(8'(8'h40 + i));
            check_main($sformatf("wrap%0d", i), mq.size(), m_ov, m_un, (mq.size() != 0) ? mq[0] : 8'h00);
        end

        // ---- flush mid-stream overrides a concurrent write ----
        step_main(0, 1, 1, 0, 8'hEE);
        check_main("flush_mid", 0, 0, 0, 8'h00);
        step_main(0, 0, 0, 1, 8'h00);
        check_main("underflow_after_flush", 0, 0, 1, 8'h00);
        step_main(0, 1, 0, 0, 8'h00);
        check_main("flush_clears_underflow", 0, 0, 0, 8'h00);

        // ---- reset mid-stream ----
        for (int k = 0; k < 3; k++) step_main(0, 0, 1, 0, 8'(8'hC0 + k));
        check_main("prefill", 3, 0, 0, 8'hC0);
        step_main(1, 1, 1, 1, 8'hDD);
        check_main("reset_mid", 0, 0, 0, 8'h00);
        step_main(0, 0, 1, 0, 8'h5A);
        check_main("after_reset_write", 1, 0, 0, 8'h5A);

        // ---- registered read mode ----
        step_reg(1, 0, 0, 0, 8'h00);
        check("reg reset r_valid", 32'(g_r_valid), 32'h0);
        check("reg reset r_data",  32'(g_r_data),  32'h0);
        check("reg reset empty",   32'(g_empty),   32'h1);
        step_reg(0, 0, 1, 0, 8'h3C);
        check("reg write r_valid", 32'(g_r_valid), 32'h0);
        check("reg write count",   32'(g_count),   32'h1);
        step_reg(0, 0, 0, 1, 8'h00);
        check("reg N+1 r_valid",   32'(g_r_valid), 32'h1);
        check("reg N+1 r_data",    32'(g_r_data),  32'h3C);
        check("reg N+1 empty",     32'(g_empty),   32'h1);
        step_reg(0, 0, 0, 0, 8'h00);
        check("reg N+2 r_valid",   32'(g_r_valid), 32'h0);
        check("reg N+2 r_data",    32'(g_r_data),  32'h3C);
        step_reg(0, 0, 0, 1, 8'h00);
        check("reg empty rd r_valid",   32'(g_r_valid), 32'h0);
        check("reg empty rd underflow", 32'(g_un),      32'h1);
        step_reg(0, 1, 0, 0, 8'h00);
        check("reg flush underflow",    32'(g_un),      32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
